alien_grid: RTL and testbench

Alien formation and collision stage placed directly downstream of `bullet`. It consumes `flying`, `bulletX` and `bulletY` from `bullet` and returns the one-cycle `hit` pulse that `bullet` uses to terminate its flight. It also holds the per-alien alive bitmap, marches the formation across the 32×16 playfield, and tracks score and end-of-wave conditions for the game controller.

---
 rtl/alien_grid.sv | 98 +++++++++
 tb/tb_alien_grid.sv | 185 ++++++++++++++++++
 2 files changed

// File: rtl/alien_grid.sv
// Alien formation: alive bitmap, bullet collision with 1-cycle registered hit, marching, score and end-of-wave flags.
// The collision is evaluated every cycle on current state. Marching freezes once the wave is cleared or has landed.
module alien_grid #(
    parameter int COLS     = 8,
    parameter int ROWS     = 4,
    parameter int STEP_DIV = 8,
    parameter int SCORE_W  = 8
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   clr,
    input  logic                   enable,
    input  logic                   flying,
    input  logic [4:0]             bulletX,
    input  logic [3:0]             bulletY,
    output logic                   hit,
    output logic [ROWS*COLS-1:0]   alive,
    output logic [4:0]             formX,
    output logic [3:0]             formY,
    output logic                   dir,
    output logic [SCORE_W-1:0]     score,
    output logic                   cleared,
    output logic                   landed
);
    localparam int N     = ROWS * COLS;
    localparam int DIV_W = (STEP_DIV > 1) ? $clog2(STEP_DIV) : 1;
    localparam logic [4:0]       RIGHT_EDGE = 5'(32 - (2 * COLS - 1));
    localparam logic [3:0]       LAND_Y     = 4'(16 - ROWS);
    localparam logic [DIV_W-1:0] DIV_LAST   = DIV_W'(STEP_DIV - 1);

    logic [DIV_W-1:0] div;
    logic [N-1:0]     hit_vec;
    logic [N-1:0]     alive_nxt;
    logic             collide;
    logic             frozen;
    logic             tick_en;
    logic             step;
    logic             turn;

    // Cell positions are unique, so at most one hit_vec bit can be set.
    always_comb begin
        hit_vec = '0;
        for (int r = 0; r < ROWS; r++) begin
            for (int c = 0; c < COLS; c++) begin
                if (({1'b0, bulletX} == ({1'b0, formX} + 6'(2 * c))) &&
                    ({1'b0, bulletY} == ({1'b0, formY} + 5'(r)))) begin
                    hit_vec[r*COLS+c] = flying & alive[r*COLS+c];
                end
            end
        end
    end

    assign collide   = |hit_vec;
    assign alive_nxt = alive & ~hit_vec;
    assign frozen    = landed | cleared;
    assign tick_en   = enable & ~frozen;
    assign step      = tick_en && (div == DIV_LAST);
    assign turn      = dir ? (formX == RIGHT_EDGE) : (formX == 5'd0);

    always_ff @(posedge clk) begin
        if (reset || clr) begin
            formX   <= '0;
            formY   <= '0;
            dir     <= 1'b1;
            alive   <= '1;
            hit     <= 1'b0;
            cleared <= 1'b0;
            landed  <= 1'b0;
            div     <= '0;
            if (reset) begin
                score <= '0;
            end
        end else begin
            hit   <= collide;
            alive <= alive_nxt;
            if (collide && (score != '1)) begin
                score <= score + 1'b1;
            end
            if (collide && (alive_nxt == '0)) begin
                cleared <= 1'b1;
            end
            if (tick_en) begin
                div <= step ? '0 : div + 1'b1;
            end
            if (step) begin
                if (turn) begin
                    formY <= formY + 4'd1;
                    dir   <= ~dir;
                    if ((formY + 4'd1) == LAND_Y) begin
                        landed <= 1'b1;
                    end
                end else begin
                    formX <= dir ? formX + 5'd1 : formX - 5'd1;
                end
            end
        end
    end
endmodule

// File: tb/tb_alien_grid.sv
// Directed bench for alien_grid with hand-computed expectations.
module tb_alien_grid;
    logic        clk = 1'b0;
    logic        reset = 1'b0, clr = 1'b0, enable = 1'b0, flying = 1'b0;
    logic [4:0]  bulletX = '0;
    logic [3:0]  bulletY = '0;
    logic        hit, dir, cleared, landed;
    logic [31:0] alive;
    logic [4:0]  formX;
    logic [3:0]  formY;
    logic [7:0]  score;

    int total = 0;
    int bad = 0;
    int hits = 0;
    int cyc = 0;
    logic [31:0] alive_m;
    logic        exp_hit;

    alien_grid dut (
        .clk(clk), .reset(reset), .clr(clr), .enable(enable), .flying(flying),
        .bulletX(bulletX), .bulletY(bulletY), .hit(hit), .alive(alive),
        .formX(formX), .formY(formY), .dir(dir), .score(score),
        .cleared(cleared), .landed(landed)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        total++;
        assert (got === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, got, exp);
        end
    endtask

    task automatic pulses(input int n);
        enable = 1'b1;
        repeat (n) tick();
        enable = 1'b0;
    endtask

    initial begin
        // Reset state
        reset = 1'b1;
        tick(); tick();
        reset = 1'b0;
        chk("rst_alive", alive, 32'hFFFF_FFFF);
        chk("rst_formX", formX, 0);
        chk("rst_formY", formY, 0);
        chk("rst_dir", dir, 1);
        chk("rst_score", score, 0);
        chk("rst_hit", hit, 0);
        chk("rst_cleared", cleared, 0);
        chk("rst_landed", landed, 0);

        // Lingering bullet on alien (1,1) at (2,1): exactly one hit
        flying = 1'b1; bulletX = 5'd2; bulletY = 4'd1;
        tick();
        chk("hit_first", hit, 1);
        chk("hit_alive", alive, 32'hFFFF_FDFF);
        chk("hit_score", score, 1);
        tick();
        chk("hit_linger1", hit, 0);
        tick();
        chk("hit_linger2", hit, 0);
        chk("hit_score_hold", score, 1);

        // Gap column and non-flying bullet
        bulletX = 5'd1;
        tick();
        chk("gap_nohit", hit, 0);
        flying = 1'b0; bulletX = 5'd4;
        tick();
        chk("noflying_nohit", hit, 0);
        chk("noflying_alive", alive, 32'hFFFF_FDFF);

        // March: first step lands on the 8th enable
        pulses(7);
        chk("march_7", formX, 0);
        pulses(1);
        chk("march_8", formX, 1);
        pulses(16 * 8);
        chk("march_to17", formX, 17);
        pulses(8);
        chk("turn_formX", formX, 17);
        chk("turn_formY", formY, 1);
        chk("turn_dir", dir, 0);
        pulses(8);
        chk("left_formX", formX, 16);

        // Hit on alien (0,0) at (16,1) coinciding with a step
        pulses(7);
        enable = 1'b1; flying = 1'b1; bulletX = 5'd16; bulletY = 4'd1;
        tick();
        enable = 1'b0; flying = 1'b0;
        chk("simul_hit", hit, 1);
        chk("simul_alive", alive, 32'hFFFF_FDFE);
        chk("simul_formX", formX, 15);
        chk("simul_score", score, 2);

        // Clear the wave: formation at (15,1)
        alive_m = 32'hFFFF_FDFE;
        hits = 0;
        for (int r = 0; r < 4; r++) begin
            for (int c = 0; c < 8; c++) begin
                flying = 1'b1;
                bulletX = 5'(15 + 2 * c);
                bulletY = 4'(1 + r);
                if (r == 3 && c == 7) chk("clear_not_early", cleared, 0);
                exp_hit = alive_m[r*8+c];
                tick();
                chk("clear_hit", hit, exp_hit);
                alive_m[r*8+c] = 1'b0;
                if (hit) hits++;
            end
        end
        flying = 1'b0;
        chk("clear_hits", hits, 30);
        chk("clear_score", score, 32);
        chk("clear_alive", alive, 0);
        chk("clear_flag", cleared, 1);
        pulses(16);
        chk("clear_frozen", formX, 15);

        // New wave keeps score
        clr = 1'b1;
        tick();
        clr = 1'b0;
        chk("clr_alive", alive, 32'hFFFF_FFFF);
        chk("clr_formX", formX, 0);
        chk("clr_formY", formY, 0);
        chk("clr_cleared", cleared, 0);
        chk("clr_score", score, 32);

        // March to the bottom: 12 rows * 18 steps * 8 ticks
        enable = 1'b1;
        cyc = 0;
        for (int i = 0; i < 3000 && formY != 4'd12; i++) begin
            tick();
            cyc++;
        end
        chk("land_cycles", cyc, 1728);
        chk("land_flag", landed, 1);
        chk("land_formX", formX, 0);
        chk("land_dir", dir, 1);
        repeat (40) tick();
        enable = 1'b0;
        chk("land_frozen_x", formX, 0);
        chk("land_frozen_y", formY, 12);

        // Collisions still active after landing
        flying = 1'b1; bulletX = 5'd0; bulletY = 4'd12;
        tick();
        chk("land_hit", hit, 1);
        chk("land_score", score, 33);

        // clr discards a pending collision on alien (0,0)
        bulletY = 4'd0;
        clr = 1'b1;
        tick();
        chk("clr_pending_setup_hit", hit, 0);
        clr = 1'b1;
        tick();
        clr = 1'b0; flying = 1'b0;
        chk("clr_discard_hit", hit, 0);
        chk("clr_discard_score", score, 33);
        chk("clr_landed", landed, 0);

        // Reset wins over clr
        clr = 1'b1; reset = 1'b1;
        tick();
        clr = 1'b0; reset = 1'b0;
        chk("prio_score", score, 0);
        chk("prio_alive", alive, 32'hFFFF_FFFF);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
